// File: rtl/im_port_arbiter.sv
// rtl/im_port_arbiter.sv - two-requester arbiter for the single-port instruction memory
module im_port_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_lock,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              locked,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_LD   = 2'd2;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [3:0]        wait_cnt;
    logic [1:0]        resp_owner;
    logic [DATA_W-1:0] if_hold;
    logic [DATA_W-1:0] ld_hold;

    wire unused_addr_bits = ^{if_addr[31:ADDR_W], ld_addr[31:ADDR_W]};

    // A pending or sampled lock request blocks fetch in the same cycle.
    always_comb begin
        if_gnt = 1'b0;
        ld_gnt = 1'b0;
        if (!rst) begin
            if (state == ST_LOCKED || ld_lock) begin
                ld_gnt = ld_req;
            end else if (if_req && ld_req) begin
                if (wait_cnt == WAIT_MAX) begin
                    if_gnt = 1'b1;
                end else begin
                    ld_gnt = 1'b1;
                end
            end else begin
                if_gnt = if_req;
                ld_gnt = ld_req;
            end
        end
    end

    always_comb begin
        mem_en    = if_gnt | ld_gnt;
        mem_we    = ld_gnt & ld_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_addr[ADDR_W-1:0];
        end else if (ld_gnt) begin
            mem_addr  = ld_addr[ADDR_W-1:0];
            mem_wdata = ld_wdata;
        end
    end

    // Leaving LOCKED waits for any loader read to drain first.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (ld_lock) state_nxt = ST_LOCKED;
            ST_LOCKED: if (!ld_lock && resp_owner != OWN_LD) state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            locked     <= 1'b0;
            wait_cnt   <= 4'd0;
            resp_owner <= OWN_NONE;
            if_hold    <= '0;
            ld_hold    <= '0;
        end else begin
            state  <= state_nxt;
            locked <= (state_nxt == ST_LOCKED);

            if (if_gnt) begin
                resp_owner <= OWN_IF;
            end else if (ld_gnt && !ld_we) begin
                resp_owner <= OWN_LD;
            end else begin
                resp_owner <= OWN_NONE;
            end

            if (resp_owner == OWN_IF) if_hold <= mem_rdata;
            if (resp_owner == OWN_LD) ld_hold <= mem_rdata;

            if (state == ST_LOCKED) begin
                wait_cnt <= 4'd0;
            end else if (if_req && !if_gnt) begin
                if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'd0;
            end
        end
    end

    assign if_rvalid = (resp_owner == OWN_IF);
    assign ld_rvalid = (resp_owner == OWN_LD);
    assign if_rdata  = if_rvalid ? mem_rdata : if_hold;
    assign ld_rdata  = ld_rvalid ? mem_rdata : ld_hold;

endmodule

// File: tb/tb_im_port_arbiter.sv
// tb/tb_im_port_arbiter.sv - self-checking bench for im_port_arbiter
module tb_im_port_arbiter;

    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, ld_req, ld_we, ld_lock;
    logic [31:0]       if_addr, ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              if_gnt, if_rvalid, ld_gnt, ld_rvalid, locked;
    logic [DATA_W-1:0] if_rdata, ld_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    im_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_lock(ld_lock), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .locked(locked), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Write-first synchronous IM, preloaded with word i = 0xA0000000 + i.
    logic [DATA_W-1:0] im [DEPTH];
    logic              im_ready = 1'b0;
    always @(posedge clk) begin
        if (!im_ready) begin
            for (int i = 0; i < DEPTH; i++) im[i] <= 32'hA000_0000 + i;
            im_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) begin
                im[mem_addr] <= mem_wdata;
                mem_rdata    <= mem_wdata;
            end else begin
                mem_rdata <= im[mem_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                         input logic lr, input logic lw, input logic [31:0] la,
                         input logic [31:0] wd, input logic lk);
        rst = r; if_req = ir; if_addr = ia; ld_req = lr; ld_we = lw;
        ld_addr = la; ld_wdata = wd; ld_lock = lk;
    endtask

    // flags: {if_gnt, ld_gnt, if_rvalid, ld_rvalid, locked}
    typedef struct {
        logic        rst, if_req, ld_req, ld_we, ld_lock;
        logic [31:0] if_addr, ld_addr, wdata;
        logic [4:0]  flags;
        logic [31:0] data;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic r, input logic ir, input logic [31:0] ia,
                       input logic lr, input logic lw, input logic [31:0] la,
                       input logic [31:0] wd, input logic lk,
                       input logic [4:0] f, input logic [31:0] d);
        vec_t v;
        v.rst = r; v.if_req = ir; v.if_addr = ia; v.ld_req = lr; v.ld_we = lw;
        v.ld_addr = la; v.wdata = wd; v.ld_lock = lk; v.flags = f; v.data = d;
        vecs.push_back(v);
    endtask

    // Reference model state for the random phase.
    logic [31:0] ref_mem [DEPTH];
    bit          m_locked;
    int          m_streak;
    int          m_owner;      // 0 none, 1 fetch, 2 loader
    logic [31:0] m_resp, m_if_hold, m_ld_hold;

    task automatic model_reset();
        m_locked = 0; m_streak = 0; m_owner = 0;
        m_if_hold = '0; m_ld_hold = '0; m_resp = '0;
    endtask

    initial begin
        bit e_if, e_ld, nxt_locked;
        int n_owner;
        logic [31:0] n_resp;
        logic [10:0] ga;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hA000_0000 + i;
        drive(1, 1, 5, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        // test 1: reset with fetch requesting, then fetch stream 5,6,7
        add(1,1,5, 0,0,0,0,0, 5'b00000, 0);
        add(1,1,5, 0,0,0,0,0, 5'b00000, 0);
        add(0,1,5, 0,0,0,0,0, 5'b10000, 0);
        add(0,1,6, 0,0,0,0,0, 5'b10100, 32'hA000_0005);
        add(0,1,7, 0,0,0,0,0, 5'b10100, 32'hA000_0006);
        add(0,0,0, 0,0,0,0,0, 5'b00100, 32'hA000_0007);
        add(0,0,0, 0,0,0,0,0, 5'b00000, 0);
        // test 3: both requesting, loader wins MAX_WAIT times then fetch
        add(0,1,8, 1,0,32'h20,0,0, 5'b01000, 0);
        add(0,1,8, 1,0,32'h20,0,0, 5'b01010, 32'hA000_0020);
        add(0,1,8, 1,0,32'h20,0,0, 5'b01010, 32'hA000_0020);
        add(0,1,8, 1,0,32'h20,0,0, 5'b01010, 32'hA000_0020);
        add(0,1,8, 1,0,32'h20,0,0, 5'b10010, 32'hA000_0020);
        add(0,1,8, 1,0,32'h20,0,0, 5'b01100, 32'hA000_0008);
        add(0,1,8, 1,0,32'h20,0,0, 5'b01010, 32'hA000_0020);
        add(0,1,8, 1,0,32'h20,0,0, 5'b01010, 32'hA000_0020);
        add(0,1,8, 1,0,32'h20,0,0, 5'b01010, 32'hA000_0020);
        add(0,1,8, 1,0,32'h20,0,0, 5'b10010, 32'hA000_0020);
        add(0,0,0, 0,0,0,0,0, 5'b00100, 32'hA000_0008);
        // test 4: write then read-back by loader and fetch
        add(0,0,0, 1,1,32'h10,32'hDEADBEEF,0, 5'b01000, 0);
        add(0,0,0, 1,0,32'h10,0,0, 5'b01000, 0);
        add(0,1,32'h10, 0,0,0,0,0, 5'b10010, 32'hDEADBEEF);
        add(0,0,0, 0,0,0,0,0, 5'b00100, 32'hDEADBEEF);
        // test 5: lock blocks fetch immediately; unlock waits for loader read
        add(0,1,3, 0,0,0,0,1, 5'b00000, 0);
        add(0,1,3, 1,0,32'h11,0,1, 5'b01001, 0);
        add(0,1,3, 0,0,0,0,0, 5'b00011, 32'hA000_0011);
        add(0,1,3, 0,0,0,0,0, 5'b00001, 0);
        add(0,1,3, 0,0,0,0,0, 5'b10000, 0);
        add(0,0,0, 0,0,0,0,0, 5'b00100, 32'hA000_0003);

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].if_req, vecs[k].if_addr, vecs[k].ld_req,
                  vecs[k].ld_we, vecs[k].ld_addr, vecs[k].wdata, vecs[k].ld_lock);
            @(negedge clk);
            chk($sformatf("vec%0d_flags", k), 64'({if_gnt, ld_gnt, if_rvalid, ld_rvalid, locked}),
                64'(vecs[k].flags));
            if (vecs[k].flags[2]) chk($sformatf("vec%0d_if_rdata", k), 64'(if_rdata), 64'(vecs[k].data));
            if (vecs[k].flags[1]) chk($sformatf("vec%0d_ld_rdata", k), 64'(ld_rdata), 64'(vecs[k].data));
            @(posedge clk); #1;
        end
        // shared IM was written at word 0x10 during the table
        ref_mem[16] = 32'hDEADBEEF;

        // test 6: reset right after a fetch grant discards the response
        drive(0, 1, 9, 0, 0, 0, 0, 0);
        @(negedge clk); chk("t6_gnt", 64'(if_gnt), 64'd1);
        @(posedge clk); #1;
        drive(1, 1, 9, 1, 0, 32'h30, 0, 0);
        @(posedge clk); #1;
        drive(0, 1, 9, 1, 0, 32'h30, 0, 0);
        @(negedge clk);
        chk("t6_if_rvalid", 64'(if_rvalid), 64'd0);
        chk("t6_locked", 64'(locked), 64'd0);
        chk("t6_if_rdata", 64'(if_rdata), 64'd0);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            chk($sformatf("t6_arb%0d", c), 64'({if_gnt, ld_gnt}), (c == 4) ? 64'd2 : 64'd1);
            @(posedge clk); #1;
        end

        // random phase against the reference model
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        model_reset();
        ld_lock = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                  {($urandom_range(0, 7) == 0) ? 21'($urandom) : 21'd0, 11'($urandom_range(0, 31))},
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
                  {($urandom_range(0, 7) == 0) ? 21'($urandom) : 21'd0, 11'($urandom_range(0, 31))},
                  $urandom, ($urandom_range(0, 15) == 0) ? !ld_lock : ld_lock);
            @(negedge clk);
            e_if = 0; e_ld = 0;
            if (!rst) begin
                if (m_locked || ld_lock) e_ld = ld_req;
                else if (if_req && ld_req) begin
                    e_if = (m_streak >= MAX_WAIT);
                    e_ld = !e_if;
                end else begin
                    e_if = if_req; e_ld = ld_req;
                end
            end
            chk("rnd_gnt", 64'({if_gnt, ld_gnt}), 64'({e_if, e_ld}));
            chk("rnd_rvalid", 64'({if_rvalid, ld_rvalid}), 64'({m_owner == 1, m_owner == 2}));
            chk("rnd_if_rdata", 64'(if_rdata), 64'((m_owner == 1) ? m_resp : m_if_hold));
            chk("rnd_ld_rdata", 64'(ld_rdata), 64'((m_owner == 2) ? m_resp : m_ld_hold));
            chk("rnd_locked", 64'(locked), 64'(m_locked));
            ga = e_if ? if_addr[10:0] : ld_addr[10:0];
            chk("rnd_mem", 64'({mem_en, mem_we, mem_addr}),
                64'({e_if || e_ld, e_ld && ld_we, (e_if || e_ld) ? ga : 11'd0}));

            if (rst) begin
                model_reset();
            end else begin
                n_owner = e_if ? 1 : ((e_ld && !ld_we) ? 2 : 0);
                n_resp  = ref_mem[ga];
                if (e_ld && ld_we) ref_mem[ga] = ld_wdata;
                if (m_owner == 1) m_if_hold = m_resp;
                if (m_owner == 2) m_ld_hold = m_resp;
                if (m_locked) m_streak = 0;
                else if (if_req && !e_if) m_streak = (m_streak < MAX_WAIT) ? m_streak + 1 : MAX_WAIT;
                else m_streak = 0;
                nxt_locked = m_locked ? !(!ld_lock && m_owner != 2) : ld_lock;
                m_locked = nxt_locked;
                m_owner  = n_owner;
                m_resp   = n_resp;
            end
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
